clk_div_prog: RTL and testbench

//  Multi-channel, runtime-programmable clock-enable/divider generator; successor to the fixed 50% divider.

---
 rtl/clk_div_pkg.sv | 16 +
 rtl/clk_div_chan.sv | 93 +++++++++
 rtl/clk_div_prog.sv | 49 ++++
 tb/tb_clk_div_prog.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the programmable clock-enable divider.
package clk_div_pkg;

    localparam int unsigned DEF_CNT_W = 26;

    // Period in clk_in cycles for a target frequency, truncated.
    function automatic int unsigned freq_to_period(input int unsigned base, input int unsigned f);
        return base / f;
    endfunction

    // Reset-default high time: half the period, rounded down.
    function automatic int unsigned def_high(input int unsigned period);
        return period >> 1;
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, active/shadow config, pending flag and registered outputs.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int unsigned CNT_W      = DEF_CNT_W,
    parameter int unsigned DEF_PERIOD = 10
) (
    input  logic             clk_in,
    input  logic             rst_a_p,
    input  logic             en,
    input  logic             sync,
    input  logic             cfg_we,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [CNT_W-1:0] cfg_high,
    output logic             clk_out,
    output logic             tick,
    output logic             cfg_pending
);

    localparam logic [CNT_W-1:0] RST_PERIOD = CNT_W'(DEF_PERIOD);
    localparam logic [CNT_W-1:0] RST_HIGH   = CNT_W'(def_high(DEF_PERIOD));
    localparam logic [CNT_W-1:0] MIN_PERIOD = CNT_W'(2);

    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] act_period, act_period_nxt, act_high, act_high_nxt;
    logic [CNT_W-1:0] shd_period, shd_period_nxt, shd_high, shd_high_nxt;
    logic             clk_out_nxt, tick_nxt, pend_nxt;
    logic             apply_c, wrap_c;

    assign wrap_c = (cnt == act_period - CNT_W'(1));

    // Next-state: count/outputs, then boundary apply, then shadow write (write wins the shadow).
    always_comb begin
        cnt_nxt        = cnt;
        act_period_nxt = act_period;
        act_high_nxt   = act_high;
        shd_period_nxt = shd_period;
        shd_high_nxt   = shd_high;
        pend_nxt       = cfg_pending;
        clk_out_nxt    = 1'b0;
        tick_nxt       = 1'b0;
        apply_c        = 1'b0;

        if (en) begin
            tick_nxt    = (cnt == '0);
            clk_out_nxt = (cnt < act_high);
            if (sync || wrap_c) begin
                cnt_nxt = '0;
                apply_c = 1'b1;
            end else begin
                cnt_nxt = cnt + CNT_W'(1);
            end
        end else begin
            cnt_nxt = '0;
            apply_c = 1'b1;
        end

        if (apply_c) begin
            act_period_nxt = shd_period;
            act_high_nxt   = shd_high;
            pend_nxt       = 1'b0;
        end

        if (cfg_we) begin
            shd_period_nxt = (cfg_period < MIN_PERIOD) ? MIN_PERIOD : cfg_period;
            shd_high_nxt   = cfg_high;
            pend_nxt       = 1'b1;
        end
    end

    always_ff @(posedge clk_in or posedge rst_a_p) begin
        if (rst_a_p) begin
            cnt         <= '0;
            act_period  <= RST_PERIOD;
            act_high    <= RST_HIGH;
            shd_period  <= RST_PERIOD;
            shd_high    <= RST_HIGH;
            cfg_pending <= 1'b0;
            clk_out     <= 1'b0;
            tick        <= 1'b0;
        end else begin
            cnt         <= cnt_nxt;
            act_period  <= act_period_nxt;
            act_high    <= act_high_nxt;
            shd_period  <= shd_period_nxt;
            shd_high    <= shd_high_nxt;
            cfg_pending <= pend_nxt;
            clk_out     <= clk_out_nxt;
            tick        <= tick_nxt;
        end
    end

endmodule

// File: rtl/clk_div_prog.sv
// Multi-channel runtime-programmable clock-enable generator with shadowed config.
module clk_div_prog
    import clk_div_pkg::*;
#(
    parameter int unsigned N_CH      = 2,
    parameter int unsigned BASE_FREQ = 50_000_000,
    parameter int unsigned DEF_FREQ  = 1,
    parameter int unsigned CNT_W     = DEF_CNT_W
) (
    input  logic                                   clk_in,
    input  logic                                   rst_a_p,
    input  logic [N_CH-1:0]                        en,
    input  logic                                   sync,
    input  logic                                   cfg_we,
    input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] cfg_ch,
    input  logic [CNT_W-1:0]                       cfg_period,
    input  logic [CNT_W-1:0]                       cfg_high,
    output logic [N_CH-1:0]                        clk_out,
    output logic [N_CH-1:0]                        tick,
    output logic [N_CH-1:0]                        cfg_pending
);

    localparam int unsigned CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int unsigned DEF_PERIOD = freq_to_period(BASE_FREQ, DEF_FREQ);

    logic [N_CH-1:0] ch_we_c;

    // Out-of-range cfg_ch matches no channel, so the write is dropped.
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        assign ch_we_c[i] = cfg_we && (cfg_ch == CH_W'(i));

        clk_div_chan #(
            .CNT_W      (CNT_W),
            .DEF_PERIOD (DEF_PERIOD)
        ) u_chan (
            .clk_in      (clk_in),
            .rst_a_p     (rst_a_p),
            .en          (en[i]),
            .sync        (sync),
            .cfg_we      (ch_we_c[i]),
            .cfg_period  (cfg_period),
            .cfg_high    (cfg_high),
            .clk_out     (clk_out[i]),
            .tick        (tick[i]),
            .cfg_pending (cfg_pending[i])
        );
    end

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed bench for clk_div_prog: default pattern, shadowed config, clamping, sync, reset, bad channel.
module tb_clk_div_prog;

    localparam int unsigned N_CH  = 3;
    localparam int unsigned CNT_W = 8;

    logic             clk_in = 1'b0;
    logic             rst_a_p;
    logic [N_CH-1:0]  en;
    logic             sync;
    logic             cfg_we;
    logic [1:0]       cfg_ch;
    logic [CNT_W-1:0] cfg_period;
    logic [CNT_W-1:0] cfg_high;
    logic [N_CH-1:0]  clk_out;
    logic [N_CH-1:0]  tick;
    logic [N_CH-1:0]  cfg_pending;

    int n_vec = 0;
    int n_err = 0;

    clk_div_prog #(
        .N_CH      (N_CH),
        .BASE_FREQ (100),
        .DEF_FREQ  (10),
        .CNT_W     (CNT_W)
    ) dut (
        .clk_in      (clk_in),
        .rst_a_p     (rst_a_p),
        .en          (en),
        .sync        (sync),
        .cfg_we      (cfg_we),
        .cfg_ch      (cfg_ch),
        .cfg_period  (cfg_period),
        .cfg_high    (cfg_high),
        .clk_out     (clk_out),
        .tick        (tick),
        .cfg_pending (cfg_pending)
    );

    always #5 clk_in = ~clk_in;

    task automatic check_val(input string tag, input int unsigned got, input int unsigned exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    // Advance n cycles, checking channel c against period p / high h starting at phase ph0.
    task automatic run_pat(input string tag, input int c, input int n,
                           input int p, input int h, input int ph0);
        int ph;
        for (int k = 0; k < n; k++) begin
            step();
            ph = (ph0 + k) % p;
            check_val({tag, "_tick"}, 32'(tick[c]), (ph == 0) ? 1 : 0);
            check_val({tag, "_clk"}, 32'(clk_out[c]), (ph < h) ? 1 : 0);
        end
    endtask

    task automatic cfg_set(input int ch, input int p, input int h);
        cfg_we     = 1'b1;
        cfg_ch     = 2'(ch);
        cfg_period = CNT_W'(p);
        cfg_high   = CNT_W'(h);
    endtask

    initial begin
        rst_a_p = 1'b1; en = '0; sync = 1'b0;
        cfg_we = 1'b0; cfg_ch = '0; cfg_period = '0; cfg_high = '0;
        repeat (2) step();
        check_val("rst_clk", 32'(clk_out), 0);
        check_val("rst_tick", 32'(tick), 0);
        check_val("rst_pend", 32'(cfg_pending), 0);
        rst_a_p = 1'b0;
        step();

        // Default 10-cycle, 5-high pattern on ch0
        en = 3'b001;
        run_pat("t1_def", 0, 20, 10, 5, 0);

        // ch1 reconfigured mid-period; current period finishes first
        en = 3'b011;
        run_pat("t2_pre", 1, 3, 10, 5, 0);
        cfg_set(1, 4, 1);
        run_pat("t2_wr", 1, 1, 10, 5, 3);
        cfg_we = 1'b0;
        check_val("t2_pend_set", 32'(cfg_pending), 2);
        run_pat("t2_old", 1, 5, 10, 5, 4);
        check_val("t2_pend_hold", 32'(cfg_pending), 2);
        run_pat("t2_wrap", 1, 1, 10, 5, 9);
        check_val("t2_pend_clr", 32'(cfg_pending), 0);
        run_pat("t2_new", 1, 8, 4, 1, 0);

        // Clamping: period 0 -> 2 stuck low; then high >= period stuck high
        en = 3'b010;
        step();
        check_val("t3_dis_clk", 32'(clk_out[0]), 0);
        check_val("t3_dis_tick", 32'(tick[0]), 0);
        cfg_set(0, 0, 0);
        step();
        cfg_we = 1'b0;
        check_val("t3_pend_set", 32'(cfg_pending), 1);
        step();
        check_val("t3_pend_clr", 32'(cfg_pending), 0);
        en = 3'b011;
        run_pat("t3_p2", 0, 6, 2, 0, 0);
        cfg_set(0, 3, 7);
        run_pat("t3_wr", 0, 1, 2, 0, 0);
        cfg_we = 1'b0;
        check_val("t3_pend2_set", 32'(cfg_pending), 1);
        run_pat("t3_wrap", 0, 1, 2, 0, 1);
        check_val("t3_pend2_clr", 32'(cfg_pending), 0);
        run_pat("t3_hi", 0, 6, 3, 7, 0);

        // sync realigns channels and applies ch1's pending config
        en = 3'b001;
        step();
        en = 3'b011;
        run_pat("t4_ph0", 1, 1, 4, 1, 0);
        cfg_set(1, 5, 2);
        run_pat("t4_wr", 1, 1, 4, 1, 1);
        cfg_we = 1'b0;
        check_val("t4_pend_set", 32'(cfg_pending), 2);
        sync = 1'b1;
        run_pat("t4_sync", 1, 1, 4, 1, 2);
        sync = 1'b0;
        check_val("t4_pend_clr", 32'(cfg_pending), 0);
        step();
        check_val("t4_tick_aligned", 32'(tick), 3);
        check_val("t4_clk1", 32'(clk_out[1]), 1);
        run_pat("t4_new", 1, 9, 5, 2, 1);

        // Async reset mid-high-phase with a pending write
        cfg_set(1, 6, 3);
        run_pat("t5_wr", 1, 1, 5, 2, 0);
        cfg_we = 1'b0;
        check_val("t5_pend_set", 32'(cfg_pending), 2);
        #2 rst_a_p = 1'b1;
        #1;
        check_val("t5_rst_clk", 32'(clk_out), 0);
        check_val("t5_rst_tick", 32'(tick), 0);
        check_val("t5_rst_pend", 32'(cfg_pending), 0);
        step();
        rst_a_p = 1'b0;
        run_pat("t5_def", 0, 12, 10, 5, 0);

        // Out-of-range channel write is dropped
        cfg_set(3, 4, 2);
        run_pat("t6_bad", 0, 1, 10, 5, 2);
        cfg_we = 1'b0;
        check_val("t6_bad_pend", 32'(cfg_pending), 0);

        // Write on a wrap edge: old shadow applied, new one on the following wrap
        cfg_set(0, 6, 3);
        run_pat("t6_wr1", 0, 1, 10, 5, 3);
        cfg_we = 1'b0;
        check_val("t6_pend1", 32'(cfg_pending), 1);
        run_pat("t6_old", 0, 5, 10, 5, 4);
        cfg_set(0, 4, 1);
        run_pat("t6_wrap_wr", 0, 1, 10, 5, 9);
        cfg_we = 1'b0;
        check_val("t6_pend_keep", 32'(cfg_pending), 1);
        run_pat("t6_mid", 0, 5, 6, 3, 0);
        check_val("t6_pend_mid", 32'(cfg_pending), 1);
        run_pat("t6_mid_wrap", 0, 1, 6, 3, 5);
        check_val("t6_pend_clr", 32'(cfg_pending), 0);
        run_pat("t6_last", 0, 8, 4, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
